// File: rtl/stats_pkg.sv
// rtl/stats_pkg.sv - shared FSM encoding, accumulator width helper and mode encodings
// Contents:
//   state_e        2-bit run-control states IDLE/ACCUM/DIVIDE/FINISH
//   MODE_*         values accepted by the SIGNED_MODE parameter
//   acc_w()        accumulator width for a given sample width and count width
package stats_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;

  // A sum of up to 2^cnt_w-1 samples of data_w bits always fits in data_w+cnt_w bits.
  function automatic int acc_w(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

endpackage

// File: rtl/stats_engine_if.sv
// rtl/stats_engine_if.sv - control, sample stream and result bundle of stats_engine
// Signals:
//   START, COUNT          run request and run length (master -> engine)
//   IN_VALID, IN_DATA     sample stream (master -> engine)
//   IN_READY              engine accepts a sample (engine -> master)
//   BUSY, DONE, ERROR     run status (engine -> master)
//   MAX, MIN, SUM,        results of the last completed run (engine -> master)
//   QUOTIENT, REMAINDER
// Modports: master (control unit side), slave (engine side).
interface stats_engine_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  localparam int ACC_W = stats_pkg::acc_w(DATA_W, CNT_W);

  logic              START;
  logic [CNT_W-1:0]  COUNT;
  logic              IN_VALID;
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_READY;
  logic              BUSY;
  logic              DONE;
  logic              ERROR;
  logic [DATA_W-1:0] MAX;
  logic [DATA_W-1:0] MIN;
  logic [ACC_W-1:0]  SUM;
  logic [DATA_W-1:0] QUOTIENT;
  logic [CNT_W-1:0]  REMAINDER;

  modport master (
    output START, COUNT, IN_VALID, IN_DATA,
    input  IN_READY, BUSY, DONE, ERROR, MAX, MIN, SUM, QUOTIENT, REMAINDER
  );

  modport slave (
    input  START, COUNT, IN_VALID, IN_DATA,
    output IN_READY, BUSY, DONE, ERROR, MAX, MIN, SUM, QUOTIENT, REMAINDER
  );

endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        load dividend and perform the first iteration this cycle
//   dividend     DVD_W-bit unsigned dividend (sampled only with start)
//   divisor      DVS_W-bit unsigned divisor, must be nonzero and held for the whole division
//   quotient     DVD_W-bit quotient, final once done is high
//   remainder    DVS_W-bit remainder, final once done is high
//   done         one-cycle pulse in the cycle after the last of DVD_W iterations
module seq_divider #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(DVD_W + 1);

  // quo_q starts as the dividend; each iteration shifts out one dividend bit at
  // the top and shifts in one quotient bit at the bottom.
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [DVD_W-1:0] src_quo;
  logic [DVS_W-1:0] src_rem;
  logic [DVS_W:0]   trial;
  logic             iterate;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    src_quo = start ? dividend : quo_q;
    src_rem = start ? '0 : rem_q;
    trial   = {src_rem, src_quo[DVD_W-1]};
    iterate = start || (cnt_q != '0);
    if (iterate) begin
      cnt_d  = start ? CW'(DVD_W - 1) : (cnt_q - CW'(1));
      done_d = (cnt_d == '0);
      if (trial >= {1'b0, divisor}) begin
        // trial < 2*divisor here, so the difference fits in DVS_W bits
        rem_d = trial[DVS_W-1:0] - divisor;
        quo_d = {src_quo[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DVS_W-1:0];
        quo_d = {src_quo[DVD_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/stats_engine.sv
// rtl/stats_engine.sv - MAX/MIN/SUM/average accelerator over a run of COUNT samples
// Ports:
//   CLK     clock
//   RESET   synchronous active-high reset
//   bus     stats_engine_if.slave: START/COUNT request, IN_VALID/IN_DATA/IN_READY
//           sample stream, BUSY/DONE/ERROR status and MAX/MIN/SUM/QUOTIENT/REMAINDER
//           results (held from one DONE to the next)
module stats_engine
  import stats_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int SIGNED_MODE = MODE_UNSIGNED
) (
  input  logic           CLK,
  input  logic           RESET,
  stats_engine_if.slave  bus
);

  localparam int  ACC_W  = acc_w(DATA_W, CNT_W);
  localparam bit  IS_SGN = (SIGNED_MODE == MODE_SIGNED);

  function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (IS_SGN) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  state_e state_q, state_d;

  // Working registers
  logic [CNT_W-1:0]  left_q, left_d;      // samples still to accept
  logic [CNT_W-1:0]  len_q, len_d;        // latched COUNT, used as divisor
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic              first_q, first_d;
  logic              launch_q, launch_d;  // high in the first DIVIDE cycle

  // Result registers seen on the bus
  logic [DATA_W-1:0] res_max_q, res_max_d;
  logic [DATA_W-1:0] res_min_q, res_min_d;
  logic [ACC_W-1:0]  res_sum_q, res_sum_d;
  logic [DATA_W-1:0] res_quo_q, res_quo_d;
  logic [CNT_W-1:0]  res_rem_q, res_rem_d;
  logic              res_err_q, res_err_d;

  logic              in_ready, busy, done;
  logic              accept, last_accept;
  logic [ACC_W-1:0]  sample_ext;
  logic              sum_neg;
  logic [ACC_W-1:0]  sum_mag;
  logic [ACC_W-1:0]  div_quo;
  logic [CNT_W-1:0]  div_rem;
  logic              div_done;
  logic [DATA_W-1:0] quo_mag, quo_res;
  logic              unused_quo_hi;

  assign accept      = in_ready && bus.IN_VALID;
  assign last_accept = accept && (left_q == CNT_W'(1));

  assign sample_ext = IS_SGN ? {{CNT_W{bus.IN_DATA[DATA_W-1]}}, bus.IN_DATA}
                             : {{CNT_W{1'b0}}, bus.IN_DATA};

  // The divider works on magnitudes; the sign is reapplied to the quotient only.
  assign sum_neg = IS_SGN && sum_q[ACC_W-1];
  assign sum_mag = sum_neg ? (~sum_q + ACC_W'(1)) : sum_q;

  // An average always fits in DATA_W bits, so the upper quotient bits are zero.
  assign quo_mag       = div_quo[DATA_W-1:0];
  assign quo_res       = sum_neg ? (~quo_mag + DATA_W'(1)) : quo_mag;
  assign unused_quo_hi = ^div_quo[ACC_W-1:DATA_W];

  seq_divider #(
    .DVD_W (ACC_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk       (CLK),
    .rst       (RESET),
    .start     (launch_q),
    .dividend  (sum_mag),
    .divisor   (len_q),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = (bus.COUNT == '0) ? FINISH : ACCUM;
      ACCUM:   if (last_accept) state_d = DIVIDE;
      DIVIDE:  if (div_done) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == ACCUM);
    busy     = (state_q != IDLE);
    done     = (state_q == FINISH);
  end

  // Datapath and result loading
  always_comb begin
    left_d    = left_q;
    len_d     = len_q;
    sum_d     = sum_q;
    max_d     = max_q;
    min_d     = min_q;
    first_d   = first_q;
    launch_d  = last_accept;
    res_max_d = res_max_q;
    res_min_d = res_min_q;
    res_sum_d = res_sum_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    res_err_d = res_err_q;

    if ((state_q == IDLE) && bus.START) begin
      left_d  = bus.COUNT;
      len_d   = bus.COUNT;
      sum_d   = '0;
      max_d   = '0;
      min_d   = '0;
      first_d = 1'b1;
    end

    if (accept) begin
      left_d  = left_q - CNT_W'(1);
      sum_d   = sum_q + sample_ext;
      first_d = 1'b0;
      if (first_q || greater(bus.IN_DATA, max_q)) max_d = bus.IN_DATA;
      if (first_q || greater(min_q, bus.IN_DATA)) min_d = bus.IN_DATA;
    end

    // Results change only on the edge into FINISH, so they are valid with DONE.
    if ((state_q == IDLE) && (state_d == FINISH)) begin
      res_max_d = '0;
      res_min_d = '0;
      res_sum_d = '0;
      res_quo_d = '0;
      res_rem_d = '0;
      res_err_d = 1'b1;
    end else if ((state_q == DIVIDE) && (state_d == FINISH)) begin
      res_max_d = max_q;
      res_min_d = min_q;
      res_sum_d = sum_q;
      res_quo_d = quo_res;
      res_rem_d = div_rem;
      res_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      left_q    <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      first_q   <= 1'b0;
      launch_q  <= 1'b0;
      res_max_q <= '0;
      res_min_q <= '0;
      res_sum_q <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      left_q    <= left_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      min_q     <= min_d;
      first_q   <= first_d;
      launch_q  <= launch_d;
      res_max_q <= res_max_d;
      res_min_q <= res_min_d;
      res_sum_q <= res_sum_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      res_err_q <= res_err_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.ERROR     = res_err_q;
  assign bus.MAX       = res_max_q;
  assign bus.MIN       = res_min_q;
  assign bus.SUM       = res_sum_q;
  assign bus.QUOTIENT  = res_quo_q;
  assign bus.REMAINDER = res_rem_q;

endmodule

// File: tb/tb_stats_engine.sv
// tb/tb_stats_engine.sv - scoreboard bench for stats_engine, unsigned and signed instances
module tb_stats_engine;

  typedef struct {
    logic [7:0]  mx;
    logic [7:0]  mn;
    logic [15:0] sm;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        e;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stats_engine_if #(.DATA_W(8), .CNT_W(8)) uif ();
  stats_engine_if #(.DATA_W(8), .CNT_W(8)) sif ();

  stats_engine #(.DATA_W(8), .CNT_W(8), .SIGNED_MODE(0)) u_dut (.CLK(clk), .RESET(rst), .bus(uif));
  stats_engine #(.DATA_W(8), .CNT_W(8), .SIGNED_MODE(1)) s_dut (.CLK(clk), .RESET(rst), .bus(sif));

  int      errors = 0;
  int      checks = 0;
  int      stim[$];
  result_t exp_u[$];
  result_t exp_s[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the sample list.
  function automatic result_t model(input bit sgn, input int count);
    result_t           r;
    longint            s;
    int                mx, mn, v;
    logic signed [7:0] b;
    s = 0; mx = 0; mn = 0;
    for (int i = 0; i < count; i++) begin
      b = stim[i][7:0];
      v = sgn ? int'(b) : int'(stim[i][7:0]);
      if (i == 0 || v > mx) mx = v;
      if (i == 0 || v < mn) mn = v;
      s += v;
    end
    r.mx = 8'(mx);
    r.mn = 8'(mn);
    r.sm = 16'(s);
    if (count == 0) begin
      r.q = 8'd0; r.r = 8'd0; r.e = 1'b1;
    end else begin
      r.q = 8'(s / count);
      r.r = 8'(((s < 0) ? -s : s) % count);
      r.e = 1'b0;
    end
    return r;
  endfunction

  function automatic result_t get_out(input bit sel);
    result_t o;
    if (sel) begin
      o.mx = sif.MAX; o.mn = sif.MIN; o.sm = sif.SUM; o.q = sif.QUOTIENT; o.r = sif.REMAINDER; o.e = sif.ERROR;
    end else begin
      o.mx = uif.MAX; o.mn = uif.MIN; o.sm = uif.SUM; o.q = uif.QUOTIENT; o.r = uif.REMAINDER; o.e = uif.ERROR;
    end
    return o;
  endfunction

  function automatic bit rdy(input bit sel);
    return sel ? sif.IN_READY : uif.IN_READY;
  endfunction

  function automatic bit busy(input bit sel);
    return sel ? sif.BUSY : uif.BUSY;
  endfunction

  task automatic cmp_out(input string p, input result_t o, input result_t e);
    chk({p, "max"}, o.mx, e.mx);
    chk({p, "min"}, o.mn, e.mn);
    chk({p, "sum"}, o.sm, e.sm);
    chk({p, "quotient"}, o.q, e.q);
    chk({p, "remainder"}, o.r, e.r);
    chk({p, "error"}, o.e, e.e);
  endtask

  task automatic check_zero(input bit sel, input string p);
    result_t z;
    z.mx = 0; z.mn = 0; z.sm = 0; z.q = 0; z.r = 0; z.e = 0;
    cmp_out(p, get_out(sel), z);
    chk({p, "busy"}, busy(sel), 0);
    chk({p, "ready"}, rdy(sel), 0);
    chk({p, "done"}, sel ? sif.DONE : uif.DONE, 0);
  endtask

  task automatic set_in(input bit sel, input bit st, input int cnt, input bit v, input int d);
    if (sel) begin
      sif.START = st; sif.COUNT = 8'(cnt); sif.IN_VALID = v; sif.IN_DATA = 8'(d);
    end else begin
      uif.START = st; uif.COUNT = 8'(cnt); uif.IN_VALID = v; uif.IN_DATA = 8'(d);
    end
  endtask

  // mode 0: IN_VALID always high, 1: random gaps, 2: toggles every other cycle
  task automatic run(input bit sel, input int count, input int mode, input bit poke);
    string p;
    int    idx, guard;
    bit    v, acc, seen_rdy;
    p = sel ? "s_" : "u_";
    if (sel) exp_s.push_back(model(1'b1, count));
    else     exp_u.push_back(model(1'b0, count));
    set_in(sel, 1'b1, count, 1'b0, 0);
    @(posedge clk); #1;
    set_in(sel, 1'b0, $urandom_range(0, 255), 1'b0, 0);
    idx = 0; guard = 0;
    while (idx < count && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (guard % 2 == 0);
      endcase
      acc = v && rdy(sel);
      set_in(sel, poke && (idx == count / 2), $urandom_range(0, 255), v,
             v ? stim[idx] : int'($urandom_range(0, 255)));
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    chk({p, "accepted_count"}, idx, count);
    guard = 0; seen_rdy = 0;
    while (busy(sel) && guard < 100) begin
      seen_rdy |= rdy(sel);
      set_in(sel, 1'b0, $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
      @(posedge clk); #1;
      guard++;
    end
    chk({p, "idle_after_run"}, busy(sel), 0);
    chk({p, "ready_low_after_last"}, seen_rdy, 0);
    set_in(sel, 1'b0, 0, 1'b0, 0);
  endtask

  // Monitors: pop and compare whenever a DUT presents DONE.
  bit prev_u = 0, prev_s = 0;

  always @(negedge clk) begin
    if (uif.DONE) begin
      chk("u_done_one_cycle", prev_u, 0);
      chk("u_done_expected", exp_u.size() != 0, 1);
      if (exp_u.size() != 0) cmp_out("u_", get_out(1'b0), exp_u.pop_front());
    end
    prev_u = uif.DONE;
  end

  always @(negedge clk) begin
    if (sif.DONE) begin
      chk("s_done_one_cycle", prev_s, 0);
      chk("s_done_expected", exp_s.size() != 0, 1);
      if (exp_s.size() != 0) cmp_out("s_", get_out(1'b1), exp_s.pop_front());
    end
    prev_s = sif.DONE;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int cyc, n;
    set_in(1'b0, 1'b0, 0, 1'b0, 0);
    set_in(1'b1, 1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero(1'b0, "u_reset_");
    check_zero(1'b1, "s_reset_");
    rst = 1'b0;
    @(posedge clk); #1;

    // basic unsigned run
    stim = '{10, 20, 30, 45};
    run(1'b0, 4, 0, 1'b0);

    // long run with stalls and an ignored START
    stim.delete();
    for (int i = 0; i < 255; i++) stim.push_back(255);
    run(1'b0, 255, 2, 1'b1);

    // zero-length run; ERROR must persist until the next DONE
    run(1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("u_error_held", uif.ERROR, 1);

    // single sample, IN_VALID held high: DONE 19 cycles after START
    stim = '{200};
    exp_u.push_back(model(1'b0, 1));
    set_in(1'b0, 1'b1, 1, 1'b1, 200);
    cyc = 0;
    while (!uif.DONE && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      uif.START = 1'b0;
    end
    chk("u_latency", cyc, 19);
    set_in(1'b0, 1'b0, 0, 1'b0, 0);
    @(posedge clk); #1;

    // reset in the middle of ACCUM after 2 of 4 samples
    set_in(1'b0, 1'b1, 4, 1'b0, 0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 0, 1'b1, 10);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 0, 1'b1, 20);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero(1'b0, "u_abort_");
    check_zero(1'b1, "s_abort_");
    repeat (25) @(posedge clk);
    #1;
    stim = '{10, 20, 30, 45};
    run(1'b0, 4, 0, 1'b0);

    // signed run with negative sum
    stim = '{8'hFB, 8'h03, 8'hFB};
    run(1'b1, 3, 0, 1'b0);

    // signed extremes: most negative sample, longest run
    stim.delete();
    for (int i = 0; i < 255; i++) stim.push_back(8'h80);
    run(1'b1, 255, 0, 1'b0);

    // signed zero-length run
    run(1'b1, 0, 1, 1'b0);

    // randomized runs on both instances
    for (int k = 0; k < 14; k++) begin
      n = $urandom_range(1, 24);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back($urandom_range(0, 255));
      run(1'(k % 2), n, $urandom_range(0, 2), k == 5);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("u_scoreboard_drained", exp_u.size(), 0);
    chk("s_scoreboard_drained", exp_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
